// File: rtl/cpu_pkg.sv
// Shared pipeline constants: Tuse/forward encodings, mult/div latencies and
// the flush FSM state type used by the hazard controller.
package cpu_pkg;

  localparam logic [2:0] TUSE_NONE = 3'd7;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam int MUL_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT = 10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and the controller's stall/forward/flush
// outputs. The controller is the slave; the pipeline (or bench) is the master.
interface hazard_ctrl_if;

  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [2:0]  tuse_rs_D;
  logic [2:0]  tuse_rt_D;
  logic        md_use_D;
  logic [4:0]  rs_E;
  logic [4:0]  rt_E;
  logic [4:0]  awrite_E;
  logic [4:0]  awrite_M;
  logic [4:0]  awrite_W;
  logic [2:0]  tnew_E;
  logic [2:0]  tnew_M;
  logic [2:0]  tnew_W;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        exc_req_M;

  logic        stall;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic        md_busy;
  logic        clear_all;
  logic        pc_redirect;
  logic [31:0] stall_count;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D, rs_E, rt_E,
           awrite_E, awrite_M, awrite_W, tnew_E, tnew_M, tnew_W,
           md_start_E, md_is_div_E, exc_req_M,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           md_busy, clear_all, pc_redirect, stall_count
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D, rs_E, rt_E,
           awrite_E, awrite_M, awrite_W, tnew_E, tnew_M, tnew_W,
           md_start_E, md_is_div_E, exc_req_M,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           md_busy, clear_all, pc_redirect, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-source forward selector: picks the youngest stage (E > M > W) whose
// destination matches the source and whose result is already available.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] awrite_e_i,
  input  logic [4:0] awrite_m_i,
  input  logic [4:0] awrite_w_i,
  input  logic [2:0] tnew_e_i,
  input  logic [2:0] tnew_m_i,
  input  logic [2:0] tnew_w_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    // $zero is hardwired, so it never takes a forwarded value.
    if (src_i != 5'd0) begin
      if (src_i == awrite_e_i && tnew_e_i == 3'd0) begin
        sel_o = FWD_E;
      end else if (src_i == awrite_m_i && tnew_m_i == 3'd0) begin
        sel_o = FWD_M;
      end else if (src_i == awrite_w_i && tnew_w_i == 3'd0) begin
        sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall detection, forwarding selects,
// mult/div occupancy, one-cycle exception flush and a stall cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  flush_state_e state_q;
  logic [CNT_W-1:0] mdCnt_q, mdCnt_d;
  logic [31:0]      stallCount_q, stallCount_d;
  logic             dataStall, mdStall, stallInt, clearInt;

  // A producer still in E or M stalls the reader when its result arrives too late.
  function automatic logic srcStall(input logic [4:0] src, input logic [2:0] tuse);
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE && src != 5'd0) begin
      if (src == bus.awrite_E && bus.tnew_E > tuse) s = 1'b1;
      if (src == bus.awrite_M && bus.tnew_M > tuse) s = 1'b1;
    end
    return s;
  endfunction

  assign clearInt  = (state_q == FLUSH);
  assign dataStall = srcStall(bus.rs_D, bus.tuse_rs_D) | srcStall(bus.rt_D, bus.tuse_rt_D);
  assign mdStall   = bus.md_use_D && ((mdCnt_q != '0) || bus.md_start_E);
  assign stallInt  = (dataStall || mdStall) && !clearInt;

  assign bus.stall       = stallInt;
  assign bus.md_busy     = (mdCnt_q != '0);
  assign bus.clear_all   = clearInt;
  assign bus.pc_redirect = clearInt;
  assign bus.stall_count = stallCount_q;

  fwd_sel u_fwd_rs_d (
    .src_i(bus.rs_D), .awrite_e_i(bus.awrite_E), .awrite_m_i(bus.awrite_M),
    .awrite_w_i(bus.awrite_W), .tnew_e_i(bus.tnew_E), .tnew_m_i(bus.tnew_M),
    .tnew_w_i(bus.tnew_W), .sel_o(bus.fwd_rs_D)
  );
  fwd_sel u_fwd_rt_d (
    .src_i(bus.rt_D), .awrite_e_i(bus.awrite_E), .awrite_m_i(bus.awrite_M),
    .awrite_w_i(bus.awrite_W), .tnew_e_i(bus.tnew_E), .tnew_m_i(bus.tnew_M),
    .tnew_w_i(bus.tnew_W), .sel_o(bus.fwd_rt_D)
  );
  fwd_sel u_fwd_rs_e (
    .src_i(bus.rs_E), .awrite_e_i(bus.awrite_E), .awrite_m_i(bus.awrite_M),
    .awrite_w_i(bus.awrite_W), .tnew_e_i(bus.tnew_E), .tnew_m_i(bus.tnew_M),
    .tnew_w_i(bus.tnew_W), .sel_o(bus.fwd_rs_E)
  );
  fwd_sel u_fwd_rt_e (
    .src_i(bus.rt_E), .awrite_e_i(bus.awrite_E), .awrite_m_i(bus.awrite_M),
    .awrite_w_i(bus.awrite_W), .tnew_e_i(bus.tnew_E), .tnew_m_i(bus.tnew_M),
    .tnew_w_i(bus.tnew_W), .sel_o(bus.fwd_rt_E)
  );

  // An issue while the unit is occupied is dropped; the running op keeps counting.
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (bus.md_start_E && mdCnt_q == '0) begin
      mdCnt_d = bus.md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (stallInt) stallCount_d = stallCount_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdCnt_q      <= '0;
      stallCount_q <= 32'd0;
    end else begin
      mdCnt_q      <= mdCnt_d;
      stallCount_q <= stallCount_d;
    end
  end

  // Requests arriving during FLUSH are dropped, so each flush lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (bus.exc_req_M) state_q <= FLUSH;
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model predicts each cycle's
// outputs, a separate monitor compares them against the DUT on the falling edge.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  typedef struct {
    logic       reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E;
    logic [2:0] tuse_rs_D, tuse_rt_D;
    logic       md_use_D;
    logic [4:0] awrite_E, awrite_M, awrite_W;
    logic [2:0] tnew_E, tnew_M, tnew_W;
    logic       md_start_E, md_is_div_E, exc_req_M;
  } stim_t;

  typedef struct {
    bit          check;
    logic        stall;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic        md_busy, clear_all, pc_redirect;
    logic [31:0] stall_count;
  } exp_t;

  logic clk;
  logic reset;
  hazard_ctrl_if bus();

  hazard_ctrl dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t expQ[$];

  int          mdRemain;
  bit          flushPending;
  bit          modelKnown;
  logic [31:0] stallCnt;

  function automatic stim_t idleStim();
    stim_t s;
    s.reset = 1'b0;
    s.rs_D = 5'd0; s.rt_D = 5'd0; s.rs_E = 5'd0; s.rt_E = 5'd0;
    s.tuse_rs_D = TUSE_NONE; s.tuse_rt_D = TUSE_NONE;
    s.md_use_D = 1'b0;
    s.awrite_E = 5'd0; s.awrite_M = 5'd0; s.awrite_W = 5'd0;
    s.tnew_E = 3'd0; s.tnew_M = 3'd0; s.tnew_W = 3'd0;
    s.md_start_E = 1'b0; s.md_is_div_E = 1'b0; s.exc_req_M = 1'b0;
    return s;
  endfunction

  // Reader must wait if a producer still in E or M delivers later than needed.
  function automatic bit needsWait(stim_t s, logic [4:0] src, logic [2:0] tuse);
    if (tuse == TUSE_NONE || src == 5'd0) return 1'b0;
    if (src == s.awrite_E && int'(s.tnew_E) > int'(tuse)) return 1'b1;
    if (src == s.awrite_M && int'(s.tnew_M) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] bypassFrom(stim_t s, logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (src == s.awrite_E && s.tnew_E == 3'd0) return 2'd1;
    if (src == s.awrite_M && s.tnew_M == 3'd0) return 2'd2;
    if (src == s.awrite_W && s.tnew_W == 3'd0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit wantStall;
    e.check = modelKnown;
    e.clear_all = flushPending;
    e.pc_redirect = flushPending;
    e.md_busy = (mdRemain > 0);
    wantStall = needsWait(s, s.rs_D, s.tuse_rs_D) || needsWait(s, s.rt_D, s.tuse_rt_D)
                || (s.md_use_D && (mdRemain > 0 || s.md_start_E));
    e.stall = wantStall && !flushPending;
    e.fwd_rs_D = bypassFrom(s, s.rs_D);
    e.fwd_rt_D = bypassFrom(s, s.rt_D);
    e.fwd_rs_E = bypassFrom(s, s.rs_E);
    e.fwd_rt_E = bypassFrom(s, s.rt_E);
    e.stall_count = stallCnt;
    return e;
  endfunction

  task automatic advanceModel(stim_t s, logic stallNow);
    if (s.reset) begin
      mdRemain = 0;
      flushPending = 1'b0;
      stallCnt = 32'd0;
      modelKnown = 1'b1;
    end else begin
      if (stallNow) stallCnt = stallCnt + 32'd1;
      if (s.md_start_E && mdRemain == 0) mdRemain = s.md_is_div_E ? 10 : 5;
      else if (mdRemain > 0) mdRemain = mdRemain - 1;
      flushPending = flushPending ? 1'b0 : bit'(s.exc_req_M);
    end
  endtask

  task automatic applyStimulus(stim_t s, bit preload);
    exp_t e;
    @(posedge clk);
    #1;
    if (preload) begin
      force dut.stallCount_q = 32'hFFFF_FFFE;
      #1;
      release dut.stallCount_q;
      stallCnt = 32'hFFFF_FFFE;
    end
    reset = s.reset;
    bus.rs_D = s.rs_D; bus.rt_D = s.rt_D; bus.rs_E = s.rs_E; bus.rt_E = s.rt_E;
    bus.tuse_rs_D = s.tuse_rs_D; bus.tuse_rt_D = s.tuse_rt_D;
    bus.md_use_D = s.md_use_D;
    bus.awrite_E = s.awrite_E; bus.awrite_M = s.awrite_M; bus.awrite_W = s.awrite_W;
    bus.tnew_E = s.tnew_E; bus.tnew_M = s.tnew_M; bus.tnew_W = s.tnew_W;
    bus.md_start_E = s.md_start_E; bus.md_is_div_E = s.md_is_div_E;
    bus.exc_req_M = s.exc_req_M;
    e = predict(s);
    expQ.push_back(e);
    advanceModel(s, e.stall);
  endtask

  task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(exp_t e);
    checkField("stall",       32'(bus.stall),       32'(e.stall));
    checkField("fwd_rs_D",    32'(bus.fwd_rs_D),    32'(e.fwd_rs_D));
    checkField("fwd_rt_D",    32'(bus.fwd_rt_D),    32'(e.fwd_rt_D));
    checkField("fwd_rs_E",    32'(bus.fwd_rs_E),    32'(e.fwd_rs_E));
    checkField("fwd_rt_E",    32'(bus.fwd_rt_E),    32'(e.fwd_rt_E));
    checkField("md_busy",     32'(bus.md_busy),     32'(e.md_busy));
    checkField("clear_all",   32'(bus.clear_all),   32'(e.clear_all));
    checkField("pc_redirect", 32'(bus.pc_redirect), 32'(e.pc_redirect));
    checkField("stall_count", bus.stall_count,      e.stall_count);
  endtask

  // Monitor: compares whatever the model predicted for the current cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.check) checkOutput(e);
    end
  end

  initial begin
    stim_t s;
    mdRemain = 0; flushPending = 1'b0; stallCnt = 32'd0; modelKnown = 1'b0;
    s = idleStim();
    s.reset = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    applyStimulus(idleStim(), 1'b0);

    $display("[TB] load-use");
    s = idleStim(); s.awrite_E = 5'd5; s.tnew_E = 3'd2; s.rs_D = 5'd5; s.tuse_rs_D = 3'd1;
    applyStimulus(s, 1'b0);
    s = idleStim(); s.awrite_M = 5'd5; s.tnew_M = 3'd1; s.rs_D = 5'd5; s.tuse_rs_D = 3'd1;
    applyStimulus(s, 1'b0);
    s = idleStim(); s.awrite_W = 5'd5; s.tnew_W = 3'd0; s.rs_D = 5'd5; s.tuse_rs_D = 3'd1;
    applyStimulus(s, 1'b0);

    $display("[TB] forward priority");
    s = idleStim(); s.awrite_E = 5'd8; s.awrite_M = 5'd8; s.rt_E = 5'd8; s.rt_D = 5'd8;
    applyStimulus(s, 1'b0);
    s.rt_E = 5'd0; s.awrite_E = 5'd0;
    applyStimulus(s, 1'b0);

    $display("[TB] divide");
    s = idleStim(); s.md_start_E = 1'b1; s.md_is_div_E = 1'b1; s.md_use_D = 1'b1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 12; i++) begin
      s = idleStim(); s.md_use_D = 1'b1;
      if (i == 4) s.md_start_E = 1'b1;
      applyStimulus(s, 1'b0);
    end
    s = idleStim(); s.md_start_E = 1'b1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(idleStim(), 1'b0);

    $display("[TB] exception flush");
    s = idleStim(); s.awrite_E = 5'd3; s.tnew_E = 3'd2; s.rt_D = 5'd3; s.tuse_rt_D = 3'd0;
    s.exc_req_M = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    s.exc_req_M = 1'b0;
    applyStimulus(s, 1'b0);
    applyStimulus(idleStim(), 1'b0);

    $display("[TB] stall counter wrap");
    s = idleStim(); s.awrite_E = 5'd9; s.tnew_E = 3'd1; s.rs_D = 5'd9; s.tuse_rs_D = 3'd0;
    applyStimulus(s, 1'b1);
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    applyStimulus(idleStim(), 1'b0);

    $display("[TB] reset mid-divide");
    s = idleStim(); s.md_start_E = 1'b1; s.md_is_div_E = 1'b1; s.md_use_D = 1'b1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(idleStim(), 1'b0);
    s = idleStim(); s.exc_req_M = 1'b1;
    applyStimulus(s, 1'b0);
    s = idleStim(); s.reset = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(idleStim(), 1'b0);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      s = idleStim();
      s.reset = ($urandom_range(0, 99) == 0);
      s.rs_D = 5'($urandom_range(0, 7)); s.rt_D = 5'($urandom_range(0, 7));
      s.rs_E = 5'($urandom_range(0, 7)); s.rt_E = 5'($urandom_range(0, 7));
      s.tuse_rs_D = ($urandom_range(0, 3) == 3) ? TUSE_NONE : 3'($urandom_range(0, 2));
      s.tuse_rt_D = ($urandom_range(0, 3) == 3) ? TUSE_NONE : 3'($urandom_range(0, 2));
      s.md_use_D = ($urandom_range(0, 2) == 0);
      s.awrite_E = 5'($urandom_range(0, 7)); s.awrite_M = 5'($urandom_range(0, 7));
      s.awrite_W = 5'($urandom_range(0, 7));
      s.tnew_E = 3'($urandom_range(0, 3)); s.tnew_M = 3'($urandom_range(0, 2));
      s.tnew_W = 3'($urandom_range(0, 1));
      s.md_start_E = ($urandom_range(0, 9) == 0);
      s.md_is_div_E = $urandom_range(0, 1) == 1;
      s.exc_req_M = ($urandom_range(0, 14) == 0);
      applyStimulus(s, 1'b0);
    end

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Compares D/E source registers with the E/M/W destination registers and Tnew values carried in the pipeline registers.
- Produces the stall, forwarding selects, mult/div busy tracking and the one-cycle clearAll flush used by every stage register.
- Keeps a stall performance counter.

Parameters:
- MUL_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.
- TUSE_NONE, 3'd7, Tuse code meaning the source is not read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs_D, rt_D  in  5 each  D-stage source register numbers
- tuse_rs_D, tuse_rt_D  in  3 each  cycles until D-stage use; TUSE_NONE means unused
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- rs_E, rt_E  in  5 each  E-stage source register numbers
- awrite_E, awrite_M, awrite_W  in  5 each  destination register per stage; 0 means none
- tnew_E, tnew_M, tnew_W  in  3 each  Tnew per stage, already decremented by the stage registers
- md_start_E  in  1  mult/div issued in E this cycle
- md_is_div_E  in  1  issued operation is a divide
- exc_req_M  in  1  exception or interrupt taken at M
- stall  out  1  freeze PC and F/D; bubble D/E
- fwd_rs_D, fwd_rt_D  out  2 each  0 = regfile, 1 = E, 2 = M, 3 = W
- fwd_rs_E, fwd_rt_E  out  2 each  same encoding
- md_busy  out  1  mult/div unit occupied
- clear_all  out  1  flush all pipeline registers
- pc_redirect  out  1  load the exception vector into PC
- stall_count  out  32  number of cycles with stall=1

Behaviour:
- Reset: the following are cleared on the next clk edge with reset=1:
  - md counter = 0, so md_busy = 0
  - FSM = RUN, so clear_all = 0 and pc_redirect = 0
  - stall_count = 0
  - the combinational outputs follow their inputs.
- Register match: src matches stage X when src != 0 and src == awrite_X.
- Data stall, for each D source whose Tuse != TUSE_NONE:
  - stall if it matches E and tnew_E > Tuse
  - stall if it matches M and tnew_M > Tuse.
  - W never causes a stall.
- MD stall: md_use_D && (md_busy || md_start_E).
- stall = (data stall || MD stall) && !clear_all. stall is combinational, with zero latency.
- Forwarding, combinational, priority E > M > W:
  - select a stage only if it matches and its tnew == 0
  - otherwise select 0 (regfile)
  - register 0 always selects 0
  - D selects are computed from rs_D/rt_D; E selects are computed from rs_E/rt_E.
- MD counter:
  - md_start_E with counter == 0 loads DIV_CYCLES if md_is_div_E, else MUL_CYCLES.
  - md_start_E while busy is ignored (no reload).
  - Otherwise the counter decrements when nonzero.
  - md_busy = (counter != 0). md_busy rises the cycle after issue.
  - Exceptions do not cancel a running operation.
- Flush FSM:
  - States RUN and FLUSH.
  - RUN goes to FLUSH when exc_req_M = 1 at the clk edge.
  - FLUSH always returns to RUN after one cycle.
  - clear_all = pc_redirect = (state == FLUSH), so the flush is exactly one cycle, one cycle after exc_req_M.
  - exc_req_M is ignored while in FLUSH.
  - Back-to-back requests produce the sequence FLUSH, RUN, FLUSH.
- stall_count:
  - increments on each edge where stall = 1 and reset = 0
  - wraps from 0xFFFFFFFF to 0.
- Reset mid-operation, for example during FLUSH or with the counter at 7: all state returns to its reset value on that edge.

Decomposition:
- Shared package cpu_pkg holds:
  - TUSE_NONE
  - FWD_RF/FWD_E/FWD_M/FWD_W encodings
  - MUL_CYCLES/DIV_CYCLES defaults
  - the flush FSM state encoding.
- One sub-module, fwd_sel: a combinational single-source forward/priority selector, instantiated 4 times.
- The stall compare, counter and FSM stay in hazard_ctrl.

Test Plan:
- Load-use: awrite_E=5, tnew_E=2, rs_D=5, tuse_rs_D=1 gives stall=1. Next cycle awrite_M=5, tnew_M=1: stall=0 and fwd_rs_D=0. Following cycle tnew_W=0 gives fwd_rs_D=3.
- Forward priority: awrite_E=awrite_M=8, tnew_E=tnew_M=0, rt_E=8 gives fwd_rt_E=1. With rt_E=0 and awrite_E=0 the result is fwd_rt_E=0.
- Divide: md_start_E=1 with md_is_div_E=1 gives md_busy=1 for exactly 10 cycles. md_use_D=1 stalls for those 10 cycles plus the issue cycle. A second md_start_E while busy does not extend md_busy.
- Exception: exc_req_M pulse gives clear_all=pc_redirect=1 for exactly one cycle, one cycle later. A simultaneous data-stall condition reads stall=0 during that cycle.
- stall_count: preload 0xFFFFFFFE via 3 stall cycles from force gives the sequence 0xFFFFFFFF, 0, 1.
- Reset mid-divide (counter=4, FSM=FLUSH) gives md_busy=0, clear_all=0 and stall_count=0 on the next edge.
